dm_sba_engine: RTL and testbench



---
 rtl/dm_pkg.sv | 39 +++
 rtl/dm_sba_engine.sv | 209 ++++++++++++++++++++
 tb/tb_dm_sba_engine.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the debug module system bus access engine:
// DMI register addresses, sbcs field positions, error codes, FSM states.
package dm_pkg;

  localparam logic [6:0] SBCS    = 7'h38;
  localparam logic [6:0] SBADDR0 = 7'h39;
  localparam logic [6:0] SBADDR1 = 7'h3A;
  localparam logic [6:0] SBDATA0 = 7'h3C;
  localparam logic [6:0] SBDATA1 = 7'h3D;

  localparam int SBCS_VER      = 29;
  localparam int SBCS_BUSYERR  = 22;
  localparam int SBCS_BUSY     = 21;
  localparam int SBCS_RDONADDR = 20;
  localparam int SBCS_ACC      = 17;
  localparam int SBCS_AUTOINC  = 16;
  localparam int SBCS_RDONDATA = 15;
  localparam int SBCS_ERR      = 12;
  localparam int SBCS_ASIZE    = 5;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_TIMEOUT = 3'd1,
    ERR_BADADDR = 3'd2,
    ERR_ALIGN   = 3'd3,
    ERR_SIZE    = 3'd4
  } sberr_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sba_state_e;

  // Low (8 << sz) bits set; sz=3 wraps to all ones.
  function automatic logic [63:0] size_mask(input logic [2:0] sz);
    return (64'd1 << (11'd8 << sz)) - 64'd1;
  endfunction

endpackage

// File: rtl/dm_sba_engine.sv
// System bus access engine: owns sbcs/sbaddress/sbdata and drives
// a single outstanding level-held request onto the system bus.
module dm_sba_engine
  import dm_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dmi_wr,
  input  logic              dmi_rd,
  input  logic [6:0]        dmi_addr,
  input  logic [31:0]       dmi_wdata,
  output logic [31:0]       dmi_rdata,
  output logic [ADDR_W-1:0] sb_addr,
  output logic [DATA_W-1:0] sb_wdata,
  output logic [2:0]        sb_size,
  output logic              sb_read,
  output logic              sb_write,
  input  logic [DATA_W-1:0] sb_rdata,
  input  logic              sb_ready,
  input  logic              sb_err
);

  sba_state_e        state_q, state_d;
  logic [ADDR_W-1:0] sbaddress_q, sbaddress_d;
  logic [DATA_W-1:0] sbdata_q, sbdata_d;
  logic [ADDR_W-1:0] sb_addr_q, sb_addr_d;
  logic [DATA_W-1:0] sb_wdata_q, sb_wdata_d;
  logic [2:0]        sb_size_q, sb_size_d;
  logic [2:0]        access_q, access_d;
  logic [2:0]        sberror_q, sberror_d;
  logic              busyerr_q, busyerr_d;
  logic              rdonaddr_q, rdonaddr_d;
  logic              autoinc_q, autoinc_d;
  logic              rdondata_q, rdondata_d;
  logic              sb_read_q, sb_read_d;
  logic              sb_write_q, sb_write_d;
  logic [31:0]       timer_q, timer_d;

  logic [63:0] addr64, data64;
  logic        is_busy, wr_bus, rd_d0;
  logic        trig_wr, trig, size_ok, misalign;

  assign addr64  = 64'(sbaddress_q);
  assign data64  = 64'(sbdata_q);
  assign is_busy = (state_q == BUSY);
  assign wr_bus  = dmi_wr && (dmi_addr inside
                   {SBADDR0, SBADDR1, SBDATA0, SBDATA1});
  assign rd_d0   = dmi_rd && !dmi_wr && (dmi_addr == SBDATA0);
  assign trig_wr = dmi_wr && (dmi_addr == SBDATA0);
  assign trig    = !is_busy && (trig_wr ||
                   (dmi_wr && dmi_addr == SBADDR0 && rdonaddr_q) ||
                   (rd_d0 && rdondata_q));
  assign size_ok = (access_q <= 3'd2) ||
                   (access_q == 3'd3 && DATA_W == 64);

  always_comb begin
    state_d     = state_q;
    sbaddress_d = sbaddress_q;
    sbdata_d    = sbdata_q;
    sb_addr_d   = sb_addr_q;
    sb_wdata_d  = sb_wdata_q;
    sb_size_d   = sb_size_q;
    access_d    = access_q;
    sberror_d   = sberror_q;
    busyerr_d   = busyerr_q;
    rdonaddr_d  = rdonaddr_q;
    autoinc_d   = autoinc_q;
    rdondata_d  = rdondata_q;
    sb_read_d   = sb_read_q;
    sb_write_d  = sb_write_q;
    timer_d     = timer_q;
    misalign    = 1'b0;

    if (dmi_wr && dmi_addr == SBCS) begin
      if (dmi_wdata[SBCS_BUSYERR]) busyerr_d = 1'b0;
      sberror_d  = sberror_q & ~dmi_wdata[SBCS_ERR +: 3];
      rdonaddr_d = dmi_wdata[SBCS_RDONADDR];
      access_d   = dmi_wdata[SBCS_ACC +: 3];
      autoinc_d  = dmi_wdata[SBCS_AUTOINC];
      rdondata_d = dmi_wdata[SBCS_RDONDATA];
    end

    if (is_busy) begin
      if (wr_bus || rd_d0) busyerr_d = 1'b1;
    end else if (dmi_wr) begin
      case (dmi_addr)
        SBADDR0: sbaddress_d = ADDR_W'({addr64[63:32], dmi_wdata});
        SBADDR1: sbaddress_d = ADDR_W'({dmi_wdata, addr64[31:0]});
        SBDATA0: sbdata_d = DATA_W'({data64[63:32], dmi_wdata});
        SBDATA1: sbdata_d = DATA_W'({dmi_wdata, data64[31:0]});
        default: ;
      endcase
    end

    unique case (state_q)
      IDLE: begin
        misalign = (64'(sbaddress_d) &
                    ((64'd1 << access_q) - 64'd1)) != 64'd0;
        if (trig && sberror_q == ERR_NONE && !busyerr_q) begin
          if (!size_ok) begin
            sberror_d = ERR_SIZE;
          end else if (misalign) begin
            sberror_d = ERR_ALIGN;
          end else begin
            state_d    = BUSY;
            timer_d    = '0;
            sb_read_d  = !trig_wr;
            sb_write_d = trig_wr;
            sb_addr_d  = sbaddress_d;
            sb_size_d  = access_q;
            sb_wdata_d = DATA_W'(64'(sbdata_d) & size_mask(access_q));
          end
        end
      end
      BUSY: begin
        timer_d = timer_q + 32'd1;
        if (sb_ready) begin
          state_d    = IDLE;
          sb_read_d  = 1'b0;
          sb_write_d = 1'b0;
          if (sb_err) begin
            sberror_d = ERR_BADADDR;
          end else begin
            if (sb_read_q)
              sbdata_d = DATA_W'(64'(sb_rdata) & size_mask(sb_size_q));
            if (autoinc_q)
              sbaddress_d = sbaddress_q + ADDR_W'(64'd1 << sb_size_q);
          end
        end else if (timer_q + 32'd1 >= 32'(TIMEOUT)) begin
          state_d    = IDLE;
          sb_read_d  = 1'b0;
          sb_write_d = 1'b0;
          sberror_d  = ERR_TIMEOUT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    logic [31:0] cs;
    cs = '0;
    cs[SBCS_VER +: 3]    = 3'd1;
    cs[SBCS_BUSYERR]     = busyerr_q;
    cs[SBCS_BUSY]        = is_busy;
    cs[SBCS_RDONADDR]    = rdonaddr_q;
    cs[SBCS_ACC +: 3]    = access_q;
    cs[SBCS_AUTOINC]     = autoinc_q;
    cs[SBCS_RDONDATA]    = rdondata_q;
    cs[SBCS_ERR +: 3]    = sberror_q;
    cs[SBCS_ASIZE +: 7]  = 7'(ADDR_W);
    cs[4:0]              = {1'b0, DATA_W == 64, 3'b111};
    case (dmi_addr)
      SBCS:    dmi_rdata = cs;
      SBADDR0: dmi_rdata = addr64[31:0];
      SBADDR1: dmi_rdata = addr64[63:32];
      SBDATA0: dmi_rdata = data64[31:0];
      SBDATA1: dmi_rdata = data64[63:32];
      default: dmi_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sbaddress_q <= '0;
      sbdata_q    <= '0;
      sb_addr_q   <= '0;
      sb_wdata_q  <= '0;
      sb_size_q   <= 3'd2;
      access_q    <= 3'd2;
      sberror_q   <= ERR_NONE;
      busyerr_q   <= 1'b0;
      rdonaddr_q  <= 1'b0;
      autoinc_q   <= 1'b0;
      rdondata_q  <= 1'b0;
      sb_read_q   <= 1'b0;
      sb_write_q  <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      sbaddress_q <= sbaddress_d;
      sbdata_q    <= sbdata_d;
      sb_addr_q   <= sb_addr_d;
      sb_wdata_q  <= sb_wdata_d;
      sb_size_q   <= sb_size_d;
      access_q    <= access_d;
      sberror_q   <= sberror_d;
      busyerr_q   <= busyerr_d;
      rdonaddr_q  <= rdonaddr_d;
      autoinc_q   <= autoinc_d;
      rdondata_q  <= rdondata_d;
      sb_read_q   <= sb_read_d;
      sb_write_q  <= sb_write_d;
      timer_q     <= timer_d;
    end
  end

  assign sb_addr  = sb_addr_q;
  assign sb_wdata = sb_wdata_q;
  assign sb_size  = sb_size_q;
  assign sb_read  = sb_read_q;
  assign sb_write = sb_write_q;

endmodule

// File: tb/tb_dm_sba_engine.sv
// Scoreboard bench for dm_sba_engine: a byte-level memory reference
// model predicts bus ops and DMI read data; a monitor checks them.
module tb_dm_sba_engine;
  import dm_pkg::*;

  localparam int TMO = 255;

  logic        clk = 0;
  logic        reset;
  logic        dmi_wr, dmi_rd;
  logic [6:0]  dmi_addr;
  logic [31:0] dmi_wdata, dmi_rdata;
  logic [31:0] sb_addr, sb_wdata, sb_rdata;
  logic [2:0]  sb_size;
  logic        sb_read, sb_write, sb_ready, sb_err;

  dm_sba_engine #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .dmi_wr(dmi_wr), .dmi_rd(dmi_rd), .dmi_addr(dmi_addr),
    .dmi_wdata(dmi_wdata), .dmi_rdata(dmi_rdata),
    .sb_addr(sb_addr), .sb_wdata(sb_wdata), .sb_size(sb_size),
    .sb_read(sb_read), .sb_write(sb_write), .sb_rdata(sb_rdata),
    .sb_ready(sb_ready), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          len;
  } bus_exp_t;

  bus_exp_t    exp_bus[$];
  logic [31:0] rd_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  logic [7:0] ref_mem[logic [31:0]];
  logic [7:0] bus_mem[logic [31:0]];

  int k_lat  = 2;
  bit k_err  = 0;
  bit k_hang = 0;

  logic [31:0] m_addr, m_data;
  logic [2:0]  m_err, m_access;
  bit m_busyerr, m_rdonaddr, m_autoinc, m_rdondata;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    logic [31:0] t;
    t = a * 32'd37 + 32'd17;
    return t[7:0];
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] bus_byte(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_byte(a);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      ref_mem[a + 32'(i)] = w[8*i +: 8];
      bus_mem[a + 32'(i)] = w[8*i +: 8];
    end
  endtask

  // Bus slave: answers after k_lat strobe cycles unless k_hang.
  initial begin
    int k;
    k = 0;
    sb_ready = 0; sb_err = 0; sb_rdata = 0;
    forever begin
      @(negedge clk);
      if (sb_read || sb_write) begin
        k++;
        if (!k_hang && k == k_lat) begin
          sb_ready = 1;
          sb_err   = k_err;
          if (sb_read)
            sb_rdata = {bus_byte(sb_addr + 3), bus_byte(sb_addr + 2),
                        bus_byte(sb_addr + 1), bus_byte(sb_addr)};
          else if (!k_err)
            for (int i = 0; i < (1 << sb_size); i++)
              bus_mem[sb_addr + 32'(i)] = sb_wdata[8*i +: 8];
        end else begin
          sb_ready = 0;
          sb_err   = 1'($urandom);
          sb_rdata = $urandom;
        end
      end else begin
        k = 0;
        sb_ready = 0;
        sb_err   = 1'($urandom);
        sb_rdata = $urandom;
      end
    end
  end

  // Monitor: DMI read data and bus requests against the scoreboard.
  initial begin
    bit prev;
    int cnt;
    bus_exp_t cur;
    prev = 0; cnt = 0;
    cur = '{0, 32'h0, 3'h0, 32'h0, 0};
    forever begin
      @(negedge clk);
      if (!reset && dmi_rd && !dmi_wr) begin
        if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("dmi_rdata", dmi_rdata, rd_q.pop_front());
      end
      if (sb_read && sb_write) chk("both_strobes", 1, 0);
      if ((sb_read || sb_write) && !prev) begin
        cnt = 1;
        if (exp_bus.size() == 0) begin
          chk("bus_unexpected", sb_addr, 32'hFFFF_FFFF);
          cur.len = -1;
        end else begin
          cur = exp_bus.pop_front();
          chk("bus_write", 32'(sb_write), 32'(cur.wr));
          chk("bus_addr", sb_addr, cur.addr);
          chk("bus_size", 32'(sb_size), 32'(cur.size));
          if (cur.wr) chk("bus_wdata", sb_wdata, cur.wdata);
        end
      end else if (sb_read || sb_write) begin
        cnt++;
      end else if (prev && cur.len >= 0) begin
        chk("strobe_len", 32'(cnt), 32'(cur.len));
      end
      prev = sb_read || sb_write;
    end
  end

  function automatic logic [31:0] m_sbcs();
    return {3'd1, 6'd0, m_busyerr, 1'b0, m_rdonaddr, m_access,
            m_autoinc, m_rdondata, m_err, 7'd32, 5'b00111};
  endfunction

  function automatic logic [31:0] mk_sbcs(input bit ra,
      input logic [2:0] acc, input bit ai, input bit rd, input bit clr);
    return {9'd0, clr, 1'b0, ra, acc, ai, rd, {3{clr}}, 12'd0};
  endfunction

  // Reference: one access from the current model state, outcome
  // decided by the responder knobs.
  task automatic m_trigger(input bit wr);
    logic [31:0] mask, w;
    if (m_err != 0 || m_busyerr) return;
    if (m_access > 2) begin m_err = 4; return; end
    if (m_addr % (32'd1 << m_access) != 0) begin m_err = 3; return; end
    mask = (m_access == 2) ? 32'hFFFF_FFFF
                           : (32'd1 << (8 << m_access)) - 1;
    exp_bus.push_back('{wr, m_addr, m_access, m_data & mask,
                        k_hang ? TMO : k_lat});
    if (k_hang) m_err = 1;
    else if (k_err) m_err = 2;
    else begin
      if (wr) begin
        for (int i = 0; i < (1 << m_access); i++)
          ref_mem[m_addr + 32'(i)] = m_data[8*i +: 8];
      end else begin
        w = {ref_byte(m_addr + 3), ref_byte(m_addr + 2),
             ref_byte(m_addr + 1), ref_byte(m_addr)};
        m_data = w & mask;
      end
      if (m_autoinc) m_addr = m_addr + (32'd1 << m_access);
    end
  endtask

  task automatic m_write(input logic [6:0] a, input logic [31:0] d);
    case (a)
      SBCS: begin
        if (d[22]) m_busyerr = 0;
        m_err      = m_err & ~d[14:12];
        m_rdonaddr = d[20];
        m_access   = d[19:17];
        m_autoinc  = d[16];
        m_rdondata = d[15];
      end
      SBADDR0: begin m_addr = d; if (m_rdonaddr) m_trigger(0); end
      SBDATA0: begin m_data = d; m_trigger(1); end
      default: ;
    endcase
  endtask

  function automatic logic [31:0] m_rdval(input logic [6:0] a);
    case (a)
      SBCS:    return m_sbcs();
      SBADDR0: return m_addr;
      SBDATA0: return m_data;
      default: return 32'h0;
    endcase
  endfunction

  task automatic dmi_write(input logic [6:0] a, input logic [31:0] d);
    dmi_addr = a; dmi_wdata = d; dmi_wr = 1;
    @(posedge clk); #1;
    dmi_wr = 0;
  endtask

  task automatic dmi_read(input logic [6:0] a, input logic [31:0] e);
    rd_q.push_back(e);
    dmi_addr = a; dmi_rd = 1;
    @(posedge clk); #1;
    dmi_rd = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb_read || sb_write) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) chk("idle_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [6:0] a, input logic [31:0] d);
    m_write(a, d);
    dmi_write(a, d);
    wait_idle();
  endtask

  task automatic do_read(input logic [6:0] a);
    logic [31:0] e;
    e = m_rdval(a);
    if (a == SBDATA0 && m_rdondata) m_trigger(0);
    dmi_read(a, e);
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; dmi_wr = 0; dmi_rd = 0; dmi_addr = 0; dmi_wdata = 0;
    m_addr = 0; m_data = 0; m_err = 0; m_access = 2;
    m_busyerr = 0; m_rdonaddr = 0; m_autoinc = 0; m_rdondata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobes", 32'({sb_read, sb_write}), 0);
    chk("rst_size", 32'(sb_size), 2);
    chk("rst_sbaddr", sb_addr, 0);
    reset = 0;
    @(posedge clk); #1;
    dmi_read(SBCS, 32'h2004_0407);
    do_read(SBADDR0);
    do_read(SBDATA0);
    do_read(SBADDR1);
    do_read(SBDATA1);
    do_read(7'h10);

    // Word read on address write.
    preload(32'h1000, 32'hDEAD_BEEF);
    k_lat = 3; k_err = 0; k_hang = 0;
    do_write(SBCS, mk_sbcs(1, 2, 0, 0, 0));
    do_write(SBADDR0, 32'h1000);
    do_read(SBDATA0);
    do_read(SBCS);

    // Byte writes with autoincrement.
    k_lat = 2;
    do_write(SBCS, mk_sbcs(0, 0, 1, 0, 0));
    do_write(SBADDR0, 32'h2003);
    repeat (3) do_write(SBDATA0, 32'h1A5);
    do_read(SBADDR0);

    // Streaming reads on sbdata0 access.
    preload(32'h0, 32'h0102_0304);
    preload(32'h4, 32'hA0B0_C0D0);
    preload(32'h8, 32'h5566_7788);
    do_write(SBCS, mk_sbcs(1, 2, 1, 1, 0));
    do_write(SBADDR0, 32'h0);
    repeat (3) do_read(SBDATA0);
    do_write(SBCS, mk_sbcs(0, 2, 1, 0, 0));
    do_read(SBADDR0);

    // Address wrap on autoincrement.
    do_write(SBADDR0, 32'hFFFF_FFFC);
    do_write(SBDATA0, 32'h7777_8888);
    do_read(SBADDR0);

    // Alignment, bus error, suppression.
    do_write(SBCS, mk_sbcs(1, 1, 0, 0, 0));
    do_write(SBADDR0, 32'h3);
    do_read(SBCS);
    do_write(SBCS, mk_sbcs(0, 2, 0, 0, 1));
    do_write(SBADDR0, 32'h400);
    k_err = 1;
    do_write(SBDATA0, 32'hCAFE_0001);
    do_read(SBCS);
    k_err = 0;
    do_write(SBDATA0, 32'hCAFE_0002);
    do_write(SBCS, mk_sbcs(0, 2, 0, 0, 1));
    do_write(SBDATA0, 32'hCAFE_0003);
    do_read(SBCS);

    // Unsupported size.
    do_write(SBCS, mk_sbcs(0, 3, 0, 0, 0));
    do_write(SBDATA0, 32'h1);
    do_read(SBCS);
    do_write(SBCS, mk_sbcs(0, 2, 0, 0, 1));

    // Timeout.
    k_hang = 1;
    do_write(SBDATA0, 32'h5151_5151);
    do_read(SBCS);
    k_hang = 0;
    do_write(SBCS, mk_sbcs(0, 2, 0, 0, 1));

    // Access while busy.
    do_write(SBADDR0, 32'h300);
    k_lat = 20;
    m_write(SBDATA0, 32'h1111_2222);
    dmi_write(SBDATA0, 32'h1111_2222);
    repeat (3) @(posedge clk);
    #1;
    dmi_write(SBDATA0, 32'h3333_4444);
    dmi_write(SBADDR0, 32'h500);
    dmi_read(SBDATA0, m_data);
    m_busyerr = 1;
    wait_idle();
    do_read(SBDATA0);
    do_read(SBADDR0);
    do_read(SBCS);
    k_lat = 2;
    do_write(SBDATA0, 32'h9);
    do_write(SBCS, mk_sbcs(0, 2, 0, 0, 1));
    do_read(SBCS);

    // Randomized mix.
    for (int it = 0; it < 80; it++) begin
      k_lat = $urandom_range(1, 5);
      k_err = ($urandom % 8) == 0;
      case ($urandom % 7)
        0: do_write(SBCS, mk_sbcs(1'($urandom),
             ($urandom % 6 == 0) ? 3'($urandom_range(3, 5))
                                 : 3'($urandom % 3),
             1'($urandom), 1'($urandom), 1'($urandom))
             | ($urandom & 32'hFF20_0FFF & ~32'h0040_0000));
        1: do_write(SBADDR0, 32'h100 + $urandom_range(0, 63));
        2, 3: do_write(SBDATA0, $urandom);
        4: do_read(SBDATA0);
        5: do_read(SBCS);
        default: do_read(SBADDR0);
      endcase
    end
    k_err = 0;
    do_write(SBCS, mk_sbcs(0, 2, 0, 0, 1));
    do_read(SBCS);

    repeat (3) @(posedge clk);
    chk("bus_q_empty", 32'(exp_bus.size()), 0);
    chk("rd_q_empty", 32'(rd_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
